// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory address, and the IF/ID
// pipeline register with freeze, branch flush, end-of-program halt and fetch counter.
module if_fetch_unit #(
    parameter int unsigned PROG_BYTES = 72,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Freeze,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchAddr,
    output logic [31:0]      Address,
    input  logic [31:0]      Instruction,
    output logic [31:0]      PC_out,
    output logic [31:0]      Instruction_out,
    output logic             Valid_out,
    output logic             Halted,
    output logic [CNT_W-1:0] FetchCount
);

    localparam logic [31:0] PROG_LIMIT = 32'(PROG_BYTES);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        in_range;
    logic        capture;

    assign in_range      = (pc < PROG_LIMIT);
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = {BranchAddr[31:2], 2'b00};
    // A real instruction enters IF/ID only when not flushed, not frozen and in range.
    assign capture       = !BranchTaken && !Freeze && in_range;

    assign Address = pc;
    assign Halted  = !in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (BranchTaken) begin
            pc <= branch_target;
        end else if (!Freeze && in_range) begin
            pc <= pc_plus4;
        end
    end

    // Out-of-range slots become bubbles; the memory word is never sampled there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Instruction_out <= 32'h0;
            PC_out          <= 32'h0;
            Valid_out       <= 1'b0;
        end else if (BranchTaken) begin
            Instruction_out <= 32'h0;
            PC_out          <= 32'h0;
            Valid_out       <= 1'b0;
        end else if (!Freeze) begin
            Instruction_out <= in_range ? Instruction : 32'h0;
            PC_out          <= pc_plus4;
            Valid_out       <= in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            FetchCount <= '0;
        end else if (capture && (FetchCount != {CNT_W{1'b1}})) begin
            FetchCount <= FetchCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random freeze/branch/reset
// traffic, all compared against a program-level reference model of the fetch stage.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        Freeze;
    logic        BranchTaken;
    logic [31:0] BranchAddr;
    logic [31:0] Instruction;
    logic [31:0] Address,  Address_s;
    logic [31:0] PC_out,   PC_out_s;
    logic [31:0] Instruction_out, Instruction_out_s;
    logic        Valid_out, Valid_out_s;
    logic        Halted,    Halted_s;
    logic [31:0] FetchCount;
    logic [3:0]  FetchCount_s;

    int passes;
    int total;

    logic [31:0] prog [18];

    // Reference state: what the ID stage should currently see.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pco;
    logic        m_val;
    int unsigned m_cnt;

    if_fetch_unit #(.PROG_BYTES(72), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Freeze(Freeze), .BranchTaken(BranchTaken),
        .BranchAddr(BranchAddr), .Address(Address), .Instruction(Instruction),
        .PC_out(PC_out), .Instruction_out(Instruction_out), .Valid_out(Valid_out),
        .Halted(Halted), .FetchCount(FetchCount)
    );

    // Narrow-counter copy sharing every input, used to exercise saturation.
    if_fetch_unit #(.PROG_BYTES(72), .RESET_PC(32'h0), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .Freeze(Freeze), .BranchTaken(BranchTaken),
        .BranchAddr(BranchAddr), .Address(Address_s), .Instruction(Instruction),
        .PC_out(PC_out_s), .Instruction_out(Instruction_out_s), .Valid_out(Valid_out_s),
        .Halted(Halted_s), .FetchCount(FetchCount_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; unpopulated addresses return an undriven word.
    always_comb begin
        if (Address < 32'd72) Instruction = prog[Address[6:2]];
        else                  Instruction = 32'hxxxx_xxxx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ins = 32'h0;
        m_pco = 32'h0;
        m_val = 1'b0;
        m_cnt = 0;
    endtask

    // One rising edge of the fetch stage, described at program level.
    task automatic model_edge();
        logic in_rng;
        in_rng = (m_pc < 32'd72);
        if (BranchTaken) begin
            m_pc  = BranchAddr & 32'hFFFF_FFFC;
            m_ins = 32'h0;
            m_pco = 32'h0;
            m_val = 1'b0;
        end else if (!Freeze) begin
            m_pco = m_pc + 32'd4;
            if (in_rng) begin
                m_ins = prog[m_pc / 4];
                m_val = 1'b1;
                m_cnt++;
                m_pc  = m_pc + 32'd4;
            end else begin
                m_ins = 32'h0;
                m_val = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned sat;
        sat = (m_cnt > 15) ? 15 : m_cnt;
        check({tag, ".addr"},  Address,         m_pc);
        check({tag, ".ins"},   Instruction_out, m_ins);
        check({tag, ".pco"},   PC_out,          m_pco);
        check({tag, ".valid"}, 32'(Valid_out),  32'(m_val));
        check({tag, ".halt"},  32'(Halted),     32'(m_pc >= 32'd72));
        check({tag, ".cnt"},   FetchCount,      m_cnt);
        check({tag, ".cnt4"},  32'(FetchCount_s), sat);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        prog[0]  = 32'hE3A00014; prog[1]  = 32'hE3A01A01; prog[2]  = 32'hE3A02C01;
        prog[3]  = 32'hE0803001; prog[4]  = 32'hE0414002; prog[5]  = 32'hE1A05104;
        prog[6]  = 32'hE3550000; prog[7]  = 32'h0A000002; prog[8]  = 32'hE2866001;
        prog[9]  = 32'hE0077005; prog[10] = 32'hE1888007; prog[11] = 32'hE5809000;
        prog[12] = 32'hE590A000; prog[13] = 32'hE28AB004; prog[14] = 32'hE15B000A;
        prog[15] = 32'hE3A00B01; prog[16] = 32'hE2400001; prog[17] = 32'hEAFFFFFE;
        passes = 0;
        total  = 0;

        // Reset values are visible before any clock edge.
        rst = 1'b0; Freeze = 1'b0; BranchTaken = 1'b0; BranchAddr = 32'h0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        tick("e1");
        check("e1.ins_const", Instruction_out, 32'hE3A00014);
        check("e1.addr_const", Address, 32'd4);
        tick("e2");
        check("e2.ins_const", Instruction_out, 32'hE3A01A01);
        check("e2.cnt_const", FetchCount, 32'd2);
        tick("e3");

        // Freeze at PC=12 for three edges, then release.
        Freeze = 1'b1;
        for (int i = 0; i < 3; i++) tick("frz");
        check("frz.addr_const", Address, 32'd12);
        Freeze = 1'b0;
        tick("unfrz");
        check("unfrz.pco_const", PC_out, 32'd16);
        tick("e5");
        tick("e6");

        // Misaligned branch coinciding with freeze at PC=24.
        check("pre_br.addr_const", Address, 32'd24);
        BranchTaken = 1'b1; BranchAddr = 32'h3E; Freeze = 1'b1;
        tick("br");
        check("br.addr_const", Address, 32'h3C);
        BranchTaken = 1'b0; Freeze = 1'b0;
        tick("br_tgt");
        check("br_tgt.ins_const", Instruction_out, 32'hE3A00B01);
        check("br_tgt.pco_const", PC_out, 32'h40);

        // Go to PC=40, freeze, then reset asynchronously between edges.
        BranchTaken = 1'b1; BranchAddr = 32'd40;
        tick("br40");
        BranchTaken = 1'b0; Freeze = 1'b1;
        tick("frz40");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b1;
        Freeze = 1'b0;
        tick("rst_e1");
        check("rst_e1.ins_const", Instruction_out, 32'hE3A00014);

        // Free-run through the whole program and into the halt region.
        for (int i = 0; i < 17; i++) tick("run");
        check("run.cnt_const", FetchCount, 32'd18);
        check("run.halt_const", 32'(Halted), 32'd1);
        for (int i = 0; i < 5; i++) tick("halt");
        check("halt.addr_const", Address, 32'd72);
        check("halt.cnt_const", FetchCount, 32'd18);
        check("halt.cnt4_const", 32'(FetchCount_s), 32'd15);

        BranchTaken = 1'b1; BranchAddr = 32'h0;
        tick("restart");
        check("restart.halt_const", 32'(Halted), 32'd0);
        BranchTaken = 1'b0;
        tick("restart1");
        tick("restart2");
        check("restart2.cnt_const", FetchCount, 32'd20);
        check("restart2.cnt4_const", 32'(FetchCount_s), 32'd15);

        // Random freeze / branch / async-reset traffic.
        for (int i = 0; i < 400; i++) begin
            Freeze      = ($urandom_range(0, 3) == 0);
            BranchTaken = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0) BranchAddr = $urandom_range(0, 95);
            else                           BranchAddr = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                #1;
                rst = 1'b1;
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
